fma_accumulate_normalize: RTL and testbench

- Sits directly downstream of the combinational `fma` dot-product stage.
- Accumulates that stage's unnormalized (sign, fixed-point mantissa sum, max exponent) results over a variable number of beats.
- At end of group: normalizes, rounds round-to-nearest-even, and packs into the same minifloat format as the `fma` operands.
- Valid/ready handshake on both sides; a multi-cycle FSM does accumulate → normalize → round/pack → hold.

---
 rtl/minifloat_pkg.sv | 29 ++
 rtl/leading_zero_counter.sv | 23 ++
 rtl/fma_accumulate_normalize.sv | 212 +++++++++++++++++++++
 tb/tb_fma_accumulate_normalize.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/minifloat_pkg.sv
// Shared minifloat definitions: format helpers, FSM states and constants used by the
// fma pipeline and its accumulate/normalize back end.
package minifloat_pkg;

    typedef enum logic [1:0] {
        ACC,
        NORM,
        ROUND,
        HOLD
    } state_e;

    function automatic int bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    function automatic int frac_bits(input int man_width, input int guard_bits);
        return 2 * man_width + guard_bits;
    endfunction

    function automatic int in_width(input int size, input int man_width, input int guard_bits);
        return $clog2(size) + 2 * (man_width + 1) + guard_bits;
    endfunction

    // Largest finite magnitude: all-ones exponent and mantissa (no Inf/NaN encodings).
    function automatic int max_mag(input int exp_width, input int man_width);
        return (1 << (exp_width + man_width)) - 1;
    endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Counts leading zeros of a word from the MSB; count equals DataWidth when the word is zero.
module leading_zero_counter #(
    parameter int  DataWidth  = 18,
    localparam int CountWidth = $clog2(DataWidth + 1)
) (
    input  logic [DataWidth-1:0]  data,
    output logic [CountWidth-1:0] count,
    output logic                  all_zero
);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count = CountWidth'(DataWidth);
        for (int i = 0; i < DataWidth; i++) begin
            if (data[i]) begin
                count = CountWidth'(DataWidth - 1 - i);
            end
        end
    end

    assign all_zero = ~|data;

endmodule

// File: rtl/fma_accumulate_normalize.sv
// Accumulates unnormalized dot-product beats from the fma stage, then normalizes, rounds
// to nearest even and packs the group total into a saturating minifloat.
module fma_accumulate_normalize
    import minifloat_pkg::*;
#(
    parameter int  ExpWidth       = 4,
    parameter int  ManWidth       = 3,
    parameter int  Size           = 4,
    parameter int  GuardBits      = 3,
    parameter int  AccHeadroom    = 4,
    localparam int InWidth        = in_width(Size, ManWidth, GuardBits),
    localparam int FracBits       = frac_bits(ManWidth, GuardBits),
    localparam int SignedExpWidth = ExpWidth + 2,
    localparam int FormatWidth    = 1 + ExpWidth + ManWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      in_last_i,
    input  logic                      sign_i,
    input  logic [InWidth-1:0]        man_i,
    input  logic [SignedExpWidth-1:0] exp_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [FormatWidth-1:0]    result_o,
    output logic                      sat_o
);

    localparam int AccWidth     = InWidth + AccHeadroom + 1;
    localparam int DiffWidth    = SignedExpWidth + 1;
    localparam int ExpCalcWidth = SignedExpWidth + 2;
    localparam int EbWidth      = ExpCalcWidth + 1;
    localparam int LzcWidth     = $clog2(AccWidth + 1);
    localparam int SigWidth     = ManWidth + 1;
    localparam int Bias         = bias(ExpWidth);
    localparam int MaxExpField  = (1 << ExpWidth) - 1;
    localparam logic [ExpWidth+ManWidth-1:0] MaxMag =
        (ExpWidth + ManWidth)'(max_mag(ExpWidth, ManWidth));

    state_e                           state, state_next;
    logic signed [AccWidth-1:0]       acc;
    logic signed [SignedExpWidth-1:0] acc_exp;
    logic                             acc_empty;
    logic                             beat_fire;

    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            ACC: begin
                in_ready_o = 1'b1;
                if (in_valid_i && in_last_i) begin
                    state_next = NORM;
                end
            end
            NORM:  state_next = ROUND;
            ROUND: state_next = HOLD;
            HOLD: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    assign beat_fire = in_valid_i & in_ready_o;

    // Alignment: the smaller-exponent operand is shifted right, shifted-out bits fold into its LSB.
    logic [AccWidth-1:0]              beat_mag, beat_val;
    logic                             exp_new_larger;
    logic signed [SignedExpWidth-1:0] big_exp, small_exp;
    logic [DiffWidth-1:0]             exp_diff, shamt;
    logic [AccWidth-1:0]              big_op, small_op, shift_mask, aligned, merged;

    always_comb begin
        beat_mag       = AccWidth'(man_i);
        beat_val       = sign_i ? -beat_mag : beat_mag;
        exp_new_larger = $signed(exp_i) > acc_exp;
        big_exp        = exp_new_larger ? $signed(exp_i) : acc_exp;
        small_exp      = exp_new_larger ? acc_exp : $signed(exp_i);
        big_op         = exp_new_larger ? beat_val : acc;
        small_op       = exp_new_larger ? acc : beat_val;
        exp_diff       = DiffWidth'(big_exp) - DiffWidth'(small_exp);
        shamt          = (exp_diff > DiffWidth'(AccWidth)) ? DiffWidth'(AccWidth) : exp_diff;
        shift_mask     = ~({AccWidth{1'b1}} << shamt);
        aligned        = $signed(small_op) >>> shamt;
        aligned[0]     = aligned[0] | (|(small_op & shift_mask));
        merged         = big_op + aligned;
    end

    logic [AccWidth-1:0] acc_mag;
    logic [LzcWidth-1:0] lz_count;
    logic                lz_zero;

    assign acc_mag = acc[AccWidth-1] ? -acc : acc;

    leading_zero_counter #(
        .DataWidth(AccWidth)
    ) u_lzc (
        .data    (acc_mag),
        .count   (lz_count),
        .all_zero(lz_zero)
    );

    logic [AccWidth-1:0]            norm_man;
    logic signed [ExpCalcWidth-1:0] norm_exp;
    logic                           norm_sign;
    logic                           norm_zero;

    // NOTE: pure datapath registers, only read in ROUND after NORM has loaded them, so no reset.
    always_ff @(posedge clk_i) begin
        if (state == NORM) begin
            norm_man  <= acc_mag << lz_count;
            norm_exp  <= ExpCalcWidth'(acc_exp) + ExpCalcWidth'(AccWidth - 1 - FracBits)
                         - ExpCalcWidth'(lz_count);
            norm_sign <= acc[AccWidth-1];
            norm_zero <= lz_zero;
        end
    end

    logic signed [EbWidth-1:0] e_b;
    logic                      denorm;
    logic [EbWidth-1:0]        dshift;
    logic [AccWidth-1:0]       den_mask, sig_src;
    logic                      lost;
    logic [SigWidth-1:0]       kept;
    logic                      round_bit, sticky, round_up;
    logic [SigWidth:0]         rounded;
    logic [EbWidth-1:0]        exp_final;
    logic                      overflow;
    logic [FormatWidth-1:0]    packed_result;
    logic                      sat_next;

    always_comb begin
        e_b    = EbWidth'(norm_exp) + EbWidth'(Bias);
        denorm = e_b[EbWidth-1] || (e_b == '0);
        dshift = EbWidth'(1) - e_b;
        if (dshift > EbWidth'(AccWidth)) begin
            dshift = EbWidth'(AccWidth);
        end
        den_mask = ~({AccWidth{1'b1}} << dshift);
        sig_src  = norm_man;
        lost     = 1'b0;
        if (denorm) begin
            sig_src = norm_man >> dshift;
            lost    = |(norm_man & den_mask);
        end
        kept      = sig_src[AccWidth-1 -: SigWidth];
        round_bit = sig_src[AccWidth-1-SigWidth];
        sticky    = (|sig_src[AccWidth-2-SigWidth:0]) | lost;
        round_up  = round_bit & (sticky | kept[0]);
        rounded   = {1'b0, kept} + {{SigWidth{1'b0}}, round_up};
        // A subnormal that rounds into the hidden bit lands exactly on the min normal exponent.
        exp_final = denorm ? EbWidth'(rounded[ManWidth])
                           : e_b + EbWidth'(rounded[SigWidth]);
        overflow  = exp_final > EbWidth'(MaxExpField);

        packed_result = {norm_sign, exp_final[ExpWidth-1:0], rounded[ManWidth-1:0]};
        sat_next      = 1'b0;
        if (norm_zero) begin
            packed_result = '0;
        end else if (overflow) begin
            packed_result = {norm_sign, MaxMag};
            sat_next      = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ACC;
            acc       <= '0;
            acc_exp   <= '0;
            acc_empty <= 1'b1;
            result_o  <= '0;
            sat_o     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ACC: begin
                    if (beat_fire) begin
                        if (acc_empty) begin
                            acc     <= beat_val;
                            acc_exp <= exp_i;
                        end else begin
                            acc     <= merged;
                            acc_exp <= big_exp;
                        end
                        acc_empty <= 1'b0;
                    end
                end
                ROUND: begin
                    result_o <= packed_result;
                    sat_o    <= sat_next;
                end
                HOLD: begin
                    if (out_ready_i) begin
                        acc       <= '0;
                        acc_exp   <= '0;
                        acc_empty <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fma_accumulate_normalize.sv
// Directed bench for fma_accumulate_normalize: table of hand-computed groups plus
// back-pressure and mid-group reset sequences.
module tb_fma_accumulate_normalize;

    localparam int IW = 13;
    localparam int EW = 6;
    localparam int NumVecs = 16;

    logic          clk_i       = 1'b0;
    logic          rst_i       = 1'b1;
    logic          in_valid_i  = 1'b0;
    logic          in_ready_o;
    logic          in_last_i   = 1'b0;
    logic          sign_i      = 1'b0;
    logic [IW-1:0] man_i       = '0;
    logic [EW-1:0] exp_i       = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [7:0]    result_o;
    logic          sat_o;

    int checks = 0;
    int errors = 0;

    fma_accumulate_normalize dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_last_i  (in_last_i),
        .sign_i     (sign_i),
        .man_i      (man_i),
        .exp_i      (exp_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .result_o   (result_o),
        .sat_o      (sat_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    typedef struct {
        int            nbeats;
        logic          s0;
        logic [IW-1:0] m0;
        logic [EW-1:0] e0;
        logic          s1;
        logic [IW-1:0] m1;
        logic [EW-1:0] e1;
        logic [7:0]    res;
        logic          sat;
    } vec_t;

    vec_t vecs[NumVecs];

    function automatic vec_t mk(input int n, input logic s0, input int m0, input int e0,
                                input logic s1, input int m1, input int e1,
                                input logic [7:0] res, input logic sat);
        vec_t v;
        v.nbeats = n;
        v.s0 = s0; v.m0 = IW'(m0); v.e0 = EW'(e0);
        v.s1 = s1; v.m1 = IW'(m1); v.e1 = EW'(e1);
        v.res = res;
        v.sat = sat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge in ACC; returns at the negedge after the accepting posedge.
    task automatic send_beat(input logic s, input logic [IW-1:0] m, input logic [EW-1:0] e,
                             input logic last);
        sign_i     = s;
        man_i      = m;
        exp_i      = e;
        in_last_i  = last;
        in_valid_i = 1'b1;
        check("in_ready during beat", 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int lat = 1;
        while (!out_valid_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        check(name, 32'(lat), 32'd3);
    endtask

    task automatic consume(input string name);
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check(name, 32'(out_valid_o), 32'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        if (v.nbeats == 2) begin
            send_beat(v.s0, v.m0, v.e0, 1'b0);
            send_beat(v.s1, v.m1, v.e1, 1'b1);
        end else begin
            send_beat(v.s0, v.m0, v.e0, 1'b1);
        end
        wait_valid($sformatf("vec%0d latency", idx));
        check($sformatf("vec%0d result", idx), 32'(result_o), 32'(v.res));
        check($sformatf("vec%0d sat", idx), 32'(sat_o), 32'(v.sat));
        consume($sformatf("vec%0d valid drop", idx));
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 512, 0, 0, 0, 0, 8'h38, 0);    // 1.0
        vecs[1]  = mk(2, 0, 512, 0, 0, 512, 0, 8'h40, 0);  // 1 + 1
        vecs[2]  = mk(2, 0, 512, 0, 1, 512, 0, 8'h00, 0);  // cancels to +0
        vecs[3]  = mk(2, 0, 512, 3, 0, 512, 0, 8'h51, 0);  // 8 + 1 = 9
        vecs[4]  = mk(1, 0, 512, 9, 0, 0, 0, 8'h7F, 1);    // 512 overflows
        vecs[5]  = mk(1, 1, 512, 9, 0, 0, 0, 8'hFF, 1);    // -512 overflows
        vecs[6]  = mk(1, 0, 544, 0, 0, 0, 0, 8'h38, 0);    // tie, stays even
        vecs[7]  = mk(1, 0, 608, 0, 0, 0, 0, 8'h3A, 0);    // tie, rounds up to even
        vecs[8]  = mk(1, 0, 512, -8, 0, 0, 0, 8'h02, 0);   // 2^-8 subnormal
        vecs[9]  = mk(1, 1, 512, 0, 0, 0, 0, 8'hB8, 0);    // -1.0
        vecs[10] = mk(1, 0, 512, 8, 0, 0, 0, 8'h78, 0);    // 256, largest exponent field
        vecs[11] = mk(1, 0, 1008, 8, 0, 0, 0, 8'h7F, 1);   // rounding carry overflows
        vecs[12] = mk(1, 0, 511, -6, 0, 0, 0, 8'h08, 0);   // subnormal rounds to min normal
        vecs[13] = mk(2, 0, 544, 4, 0, 1, 0, 8'h59, 0);    // alignment sticky breaks tie
        vecs[14] = mk(2, 1, 512, 3, 0, 512, 0, 8'hCE, 0);  // -8 + 1 = -7
        vecs[15] = mk(2, 1, 512, 0, 0, 512, 3, 8'h4E, 0);  // -1 + 8, accumulator shifted

        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("reset in_ready", 32'(in_ready_o), 32'd1);
        check("reset out_valid", 32'(out_valid_o), 32'd0);
        check("reset result", 32'(result_o), 32'd0);
        check("reset sat", 32'(sat_o), 32'd0);

        for (int i = 0; i < NumVecs; i++) begin
            run_vec(i);
        end

        // Back-pressure: result and flags must hold while downstream stalls.
        send_beat(1'b0, IW'(512), EW'(0), 1'b1);
        wait_valid("hold latency");
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d result", c), 32'(result_o), 32'h38);
            check($sformatf("hold%0d sat", c), 32'(sat_o), 32'd0);
            check($sformatf("hold%0d out_valid", c), 32'(out_valid_o), 32'd1);
            check($sformatf("hold%0d in_ready", c), 32'(in_ready_o), 32'd0);
            @(negedge clk_i);
        end
        consume("hold valid drop");

        // Leave a saturated result registered, then reset while a fresh group sits in NORM.
        run_vec(4);
        send_beat(1'b0, IW'(512), EW'(9), 1'b1);
        check("norm in_ready", 32'(in_ready_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst-norm in_ready", 32'(in_ready_o), 32'd1);
        check("rst-norm out_valid", 32'(out_valid_o), 32'd0);
        check("rst-norm result", 32'(result_o), 32'd0);
        check("rst-norm sat", 32'(sat_o), 32'd0);
        repeat (4) @(negedge clk_i);
        check("rst-norm stays idle", 32'(out_valid_o), 32'd0);
        send_beat(1'b0, IW'(608), EW'(0), 1'b1);
        wait_valid("post-reset latency");
        check("post-reset result", 32'(result_o), 32'h3A);
        check("post-reset sat", 32'(sat_o), 32'd0);
        consume("post-reset valid drop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
